digit_scan_ctrl: RTL
====================

# digit_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. It sequences the 2-bit digit `select` into the digit multiplexer and drives the active-low digit anodes, inserting a blanking gap around every select change so that no digit shows its neighbour's value. Digits can be skipped via a mask, and a per-frame strobe is provided for display-refresh bookkeeping.

## Interface
- `SCAN_DIV`, default 50000: clock cycles a digit stays lit per slot; must be ≥1.
- `BLANK_CYCLES`, default 2: clock cycles all anodes are off before each digit; must be ≥1, because the multiplexer registers its output one cycle after `select`.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: scan enable.
- `digit_mask` input 4: bit i=1 includes digit i in the scan.
- `select` output 2: digit index to the multiplexer; registered.
- `an_n` output 4: digit anodes, active-low, one-hot-low or all-high; registered.
- `blank` output 1: high whenever `an_n`=4'b1111; registered.
- `frame_done` output 1: one-cycle pulse when the scan wraps; registered.

## Operation
- States: IDLE, BLANK, SHOW. One down-counter, width $clog2(max(SCAN_DIV,BLANK_CYCLES)+1), is shared by BLANK and SHOW.
- Reset values: state IDLE, `select`=2'd0, `an_n`=4'b1111, `blank`=1, `frame_done`=0, counter 0.
- IDLE: anodes off.
  - If `en`=1 and `digit_mask`≠0, go to BLANK.
  - Set `select` to the lowest set bit of `digit_mask`.
  - Load the counter with BLANK_CYCLES−1.
- BLANK: `an_n`=4'b1111, `blank`=1.
  - When the counter reaches 0, go to SHOW and load SCAN_DIV−1.
- SHOW: `an_n` = all ones except bit `select`=0; `blank`=0.
  - When the counter reaches 0, evaluate `en` and `digit_mask` in that cycle.
  - If `en`=0 or mask=0, go to IDLE; `select` holds.
  - Otherwise compute the next digit: circular search upward from `select`+1 (mod 4) for the first set mask bit. Go to BLANK with `select`=next and load BLANK_CYCLES−1.
  - If next ≤ current `select` (wrap, including the single-digit case), pulse `frame_done` in the same cycle `select` updates.
- `select` changes only on entry to BLANK, never while a digit is lit.
- `en` or `digit_mask` changes mid-slot take effect only at slot end. A lit digit always completes its full SCAN_DIV cycles.
- Mask bits are sampled only at slot end. A digit cleared while lit finishes its slot.

## Timing
- Slot period = BLANK_CYCLES + SCAN_DIV cycles. Frame period = popcount(mask) × slot period.
- Latency from `en` rising in IDLE to the first anode low is 1 + BLANK_CYCLES cycles.
- The multiplexer output for a new `select` is valid 1 cycle later, which is always inside BLANK.
- `rst_n` low at any rising edge, in any state, forces the reset values at that edge; mid-slot state is discarded.

## Structure
- Shared package `disp_pkg`:
  - state enum `scan_state_t` {IDLE, BLANK, SHOW};
  - constant `NUM_DIGITS`=4;
  - constant `AN_OFF`=4'b1111.
- Sub-module `digit_next_sel`: combinational circular priority finder. Inputs: current index and mask. Outputs: next index and wrap flag. The IDLE entry reuses it with current index 3, so the lowest set bit is found.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYCLES=2.
- Reset: `rst_n`=0 for 3 cycles with `en`=1 → `select`=0, `an_n`=1111, `blank`=1, `frame_done`=0 throughout.
- Full scan, mask=1111, `en`=1:
  - `select` sequence 0,1,2,3,0;
  - each slot is 2 cycles of `an_n`=1111, then 4 cycles of 1110/1101/1011/0111;
  - `frame_done` pulses once, on the 3→0 step, every 24 cycles.
- Sparse mask=0101:
  - `select` alternates 0,2;
  - `an_n` alternates 1110 and 1011;
  - `frame_done` every 12 cycles.
- Single digit, mask=1000:
  - `select` stays 3;
  - `an_n`=0111 for 4 of every 6 cycles;
  - `frame_done` every 6 cycles.
- `en` drop mid-SHOW: clear `en` at cycle 1 of digit 1's slot → digit 1 stays lit 4 cycles total, then IDLE with `an_n`=1111 and `select`=1. Setting mask=0000 instead gives the same result.
- Reset mid-SHOW: `rst_n`=0 for one cycle while digit 2 is lit → reset values on the next edge. After release with `en`=1, the scan restarts at digit 0 and its anode goes low 3 cycles after `rst_n` returns high.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display scan logic.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    // Active-low anode pattern that lights exactly the selected digit.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/digit_next_sel.sv
// Circular priority finder: first set mask bit strictly after the current
// index (mod 4), wrapping back to the current index itself last.
module digit_next_sel
    import disp_pkg::*;
(
    input  logic [1:0]            cur,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [1:0]            next,
    output logic                  wrap
);

    logic       found;
    logic [1:0] idx;

    // Search cur+1, cur+2, cur+3, cur in that order; an empty mask keeps cur.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next  = cur;
        found = 1'b0;
        idx   = cur;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            idx = cur + 2'(i);
            if (!found && mask[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
        wrap = (next <= cur);
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit seven-segment display.
// Each slot is BLANK_CYCLES of all-anodes-off followed by SCAN_DIV cycles
// with one digit lit; select only moves on entry to a blank gap.
module digit_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [1:0]            select,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       search_from;
    logic [1:0]       next_sel;
    logic             next_wrap;

    // From IDLE, searching after index 3 yields the lowest set mask bit.
    assign search_from = (state == IDLE) ? 2'd3 : select;

    digit_next_sel u_next_sel (
        .cur  (search_from),
        .mask (digit_mask),
        .next (next_sel),
        .wrap (next_wrap)
    );

    // Scan FSM with shared slot counter; all outputs registered with the state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state      <= IDLE;
            select     <= 2'd0;
            an_n       <= AN_OFF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    an_n  <= AN_OFF;
                    blank <= 1'b1;
                    cnt   <= BLANK_LOAD;
                    if (en && (digit_mask != '0)) begin
                        state  <= BLANK;
                        select <= next_sel;
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state <= SHOW;
                        cnt   <= SHOW_LOAD;
                        an_n  <= anode_for(select);
                        blank <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHOW: begin
                    // en and mask are only looked at here, so a lit digit
                    // always finishes its full slot.
                    if (cnt == '0) begin
                        an_n  <= AN_OFF;
                        blank <= 1'b1;
                        if (!en || (digit_mask == '0)) begin
                            state <= IDLE;
                        end else begin
                            state      <= BLANK;
                            select     <= next_sel;
                            cnt        <= BLANK_LOAD;
                            frame_done <= next_wrap;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    an_n  <= AN_OFF;
                    blank <= 1'b1;
                end
            endcase
        end
    end

endmodule
